dma_controller: RTL and testbench

Two-channel DMA controller that sequences the shared 8-bit memory (Address/Enable/MemRead/DB_tri/DB_io bus) for memory-to-memory byte transfers. Each channel is programmed with source, destination and byte count, then moves one byte per DREQ service. The controller arbitrates between the two channels, drives the memory control lines, and captures and re-drives read data on the shared bidirectional data bus. It is the only master of the memory in the DMA subsystem.

---
 rtl/dma_pkg.sv | 8 +
 rtl/dma_arbiter.sv | 31 +++
 rtl/dma_controller.sv | 144 ++++++++++++++
 tb/tb_dma_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the two-channel DMA controller.
package dma_pkg;
  localparam int NUM_CH     = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;
endpackage

// File: rtl/dma_arbiter.sv
// Two-channel grant arbiter; ROUND_ROBIN_EN selects round robin, otherwise ch0 has fixed priority.
module dma_arbiter
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic              grant_idx
);
  logic ptr_q, ptr_d;

  // The pointer is the preferred channel; with fixed priority it never leaves ch0.
  always_comb begin
    grant_idx = req[ptr_q] ? ptr_q : ~ptr_q;
    grant     = (en && |req) ? (NUM_CH'(1) << grant_idx) : '0;
    ptr_d     = ptr_q;
`ifdef ROUND_ROBIN_EN
    if (en && |req) ptr_d = ~grant_idx;
`else
    ptr_d     = 1'b0;
`endif
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dma_controller.sv
// Two-channel memory-to-memory DMA controller, one byte per request service.
// Arbitration mode chosen by ROUND_ROBIN_EN (see dma_arbiter).
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [ADDR_W-1:0] cfg_cnt,
  input  logic [NUM_CH-1:0] dreq,
  output logic [NUM_CH-1:0] dack,
  output logic [NUM_CH-1:0] done,
  output logic              irq,
  output logic [ADDR_W-1:0] Address,
  output logic              Enable,
  output logic              MemRead,
  output logic              DB_tri,
  inout  wire  [DATA_W-1:0] DB_io
);
  state_t                         state_q, state_d;
  logic                           gidx_q, gidx_d;
  logic [NUM_CH-1:0][ADDR_W-1:0]  src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [NUM_CH-1:0]              done_q, done_d, dack_q, dack_d;
  logic [DATA_W-1:0]              data_q, data_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic                           en_q, en_d, rd_q, rd_d, tri_q, tri_d;
  logic [NUM_CH-1:0]              active, arb_grant;
  logic                           arb_idx;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) active[c] = (cnt_q[c] != '0);
  end

  dma_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (dreq & active),
    .en        (state_q == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    data_d  = data_q;
    addr_d  = addr_q;
    en_d    = en_q;
    rd_d    = rd_q;
    tri_d   = tri_q;
    dack_d  = dack_q;
    unique case (state_q)
      IDLE: if (|arb_grant) begin
        state_d = READ;
        gidx_d  = arb_idx;
        addr_d  = src_q[arb_idx];
        en_d    = 1'b1;
        rd_d    = 1'b1;
        tri_d   = 1'b1;
        dack_d  = arb_grant;
      end
      READ: begin
        state_d = CAPT;
        en_d    = 1'b0;
      end
      CAPT: begin
        state_d = WRITE;
        data_d  = DB_io;
        addr_d  = dst_q[gidx_q];
        en_d    = 1'b1;
        rd_d    = 1'b0;
        tri_d   = 1'b0;
      end
      WRITE: begin
        state_d        = IDLE;
        src_d[gidx_q]  = src_q[gidx_q] + ADDR_W'(1);
        dst_d[gidx_q]  = dst_q[gidx_q] + ADDR_W'(1);
        cnt_d[gidx_q]  = cnt_q[gidx_q] - ADDR_W'(1);
        if (cnt_q[gidx_q] == ADDR_W'(1)) done_d[gidx_q] = 1'b1;
        en_d    = 1'b0;
        dack_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    // The channel owning the bus cannot be reprogrammed mid-byte; the other one can.
    if (cfg_we && !((state_q != IDLE) && (cfg_ch == gidx_q))) begin
      src_d[cfg_ch]  = cfg_src;
      dst_d[cfg_ch]  = cfg_dst;
      cnt_d[cfg_ch]  = cfg_cnt;
      done_d[cfg_ch] = 1'b0;
    end
  end

  // NOTE: the channel register file is small and must come up idle, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gidx_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      tri_q   <= 1'b0;
      dack_q  <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      tri_q   <= tri_d;
      dack_q  <= dack_d;
    end
  end

  assign DB_io   = (state_q == WRITE) ? data_q : 'z;
  assign Address = addr_q;
  assign Enable  = en_q;
  assign MemRead = rd_q;
  assign DB_tri  = tri_q;
  assign dack    = dack_q;
  assign done    = done_q;
  assign irq     = |done_q;
endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: stimulus pushes expected byte moves, a monitor checks bus cycles.
module tb_dma_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_ch;
  logic [7:0] cfg_src, cfg_dst, cfg_cnt;
  logic [1:0] dreq, dack, done;
  logic       irq, Enable, MemRead, DB_tri;
  logic [7:0] Address;
  wire  [7:0] db_io;
  logic [7:0] mem [256];

  typedef struct {int ch; logic [7:0] src; logic [7:0] dst; logic [7:0] data;} xfer_t;
  xfer_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  dma_controller dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_cnt(cfg_cnt), .dreq(dreq), .dack(dack), .done(done),
    .irq(irq), .Address(Address), .Enable(Enable), .MemRead(MemRead),
    .DB_tri(DB_tri), .DB_io(db_io)
  );

  always #5 clk = ~clk;

  // Memory model: drives the bus while DB_tri is high, writes on Enable with MemRead low.
  assign db_io = DB_tri ? mem[Address] : 8'bz;
  always @(posedge clk) if (Enable && !MemRead) mem[Address] <= db_io;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: READ cycles check the head entry, WRITE cycles check and retire it.
  always @(negedge clk) begin
    if (!rst && Enable) begin
      if (sb.size() == 0) check("unexpected_bus_cycle", {31'd0, Enable}, 32'd0);
      else if (MemRead) begin
        check("rd_dack", {30'd0, dack}, 32'd1 << sb[0].ch);
        check("rd_addr", {24'd0, Address}, {24'd0, sb[0].src});
      end else begin
        check("wr_dack", {30'd0, dack}, 32'd1 << sb[0].ch);
        check("wr_addr", {24'd0, Address}, {24'd0, sb[0].dst});
        check("wr_data", {24'd0, db_io}, {24'd0, sb[0].data});
        void'(sb.pop_front());
      end
    end
  end

  task automatic push(input int ch, input logic [7:0] s, input logic [7:0] d, input logic [7:0] data);
    xfer_t x;
    x.ch = ch; x.src = s; x.dst = d; x.data = data;
    sb.push_back(x);
  endtask

  task automatic cfg(input logic ch, input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    cfg_we = 1'b1; cfg_ch = ch; cfg_src = s; cfg_dst = d; cfg_cnt = c;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] mask, input int bound, output int n);
    n = 0;
    while (((done & mask) != mask) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_negedge_bus(input logic want_en, input logic want_tri, input logic want_rd);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(Enable == want_en && DB_tri == want_tri && (!want_en || MemRead == want_rd)) && k < 30);
  endtask

  initial begin
    int n;
    logic bus_quiet;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_cnt = '0; dreq = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_addr",   {24'd0, Address}, 32'd0);
    check("reset_enable", {31'd0, Enable},  32'd0);
    check("reset_memrd",  {31'd0, MemRead}, 32'd0);
    check("reset_dbtri",  {31'd0, DB_tri},  32'd0);
    check("reset_dack",   {30'd0, dack},    32'd0);
    check("reset_done",   {30'd0, done},    32'd0);
    check("reset_irq",    {31'd0, irq},     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Arbitration with both channels requesting.
    cfg(1'b0, 8'd10, 8'd200, 8'd2);
    cfg(1'b1, 8'd20, 8'd210, 8'd2);
`ifdef ROUND_ROBIN_EN
    push(0, 8'd10, 8'd200, 8'd10); push(1, 8'd20, 8'd210, 8'd20);
    push(0, 8'd11, 8'd201, 8'd11); push(1, 8'd21, 8'd211, 8'd21);
`else
    push(0, 8'd10, 8'd200, 8'd10); push(0, 8'd11, 8'd201, 8'd11);
    push(1, 8'd20, 8'd210, 8'd20); push(1, 8'd21, 8'd211, 8'd21);
`endif
    dreq = 2'b11;
    wait_done(2'b11, 40, n);
    check("arb_cycles", 32'(n), 32'd16);
    check("arb_done", {30'd0, done}, 32'd3);
    @(negedge clk);
    dreq = 2'b00;
    check("arb_sb_empty", 32'(sb.size()), 32'd0);

    // Three-byte copy on ch0 with latency to done.
    cfg(1'b0, 8'd64, 8'd128, 8'd3);
    check("cfg_clears_done0", {30'd0, done}, 32'd2);
    push(0, 8'd64, 8'd128, 8'd64); push(0, 8'd65, 8'd129, 8'd65); push(0, 8'd66, 8'd130, 8'd66);
    dreq = 2'b01;
    wait_done(2'b01, 30, n);
    check("copy_cycles", 32'(n), 32'd12);
    check("copy_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    dreq = 2'b00;
    check("copy_mem128", {24'd0, mem[128]}, 32'd64);
    check("copy_mem129", {24'd0, mem[129]}, 32'd65);
    check("copy_mem130", {24'd0, mem[130]}, 32'd66);
    check("copy_sb_empty", 32'(sb.size()), 32'd0);

    // Zero count disables ch1.
    cfg(1'b1, 8'd50, 8'd60, 8'd0);
    dreq = 2'b10;
    bus_quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dack != 2'b00 || Enable) bus_quiet = 1'b0;
    end
    check("cnt0_bus_quiet", {31'd0, bus_quiet}, 32'd1);
    check("cnt0_done1", {31'd0, done[1]}, 32'd0);
    dreq = 2'b00;

    // Source address wraps from 255 to 0.
    cfg(1'b0, 8'd255, 8'd100, 8'd2);
    push(0, 8'd255, 8'd100, 8'd255); push(0, 8'd0, 8'd101, 8'd0);
    dreq = 2'b01;
    wait_done(2'b01, 20, n);
    @(negedge clk);
    dreq = 2'b00;
    check("wrap_src_reg", {24'd0, dut.src_q[0]}, 32'd1);
    check("wrap_dst_reg", {24'd0, dut.dst_q[0]}, 32'd102);
    check("wrap_mem100", {24'd0, mem[100]}, 32'd255);
    check("wrap_mem101", {24'd0, mem[101]}, 32'd0);

    // Config during WRITE: own channel ignored, other channel accepted.
    cfg(1'b0, 8'd30, 8'd150, 8'd2);
    push(0, 8'd30, 8'd150, 8'd30); push(0, 8'd31, 8'd151, 8'd31);
    dreq = 2'b01;
    wait_negedge_bus(1'b1, 1'b0, 1'b0);
    cfg(1'b0, 8'd0, 8'd0, 8'd5);
    wait_negedge_bus(1'b1, 1'b0, 1'b0);
    cfg(1'b1, 8'd40, 8'd160, 8'd1);
    wait_done(2'b01, 20, n);
    @(negedge clk);
    dreq = 2'b00;
    check("busy_cfg_src0", {24'd0, dut.src_q[0]}, 32'd32);
    check("busy_cfg_cnt0", {24'd0, dut.cnt_q[0]}, 32'd0);
    check("busy_cfg_done0", {31'd0, done[0]}, 32'd1);
    check("other_cfg_src1", {24'd0, dut.src_q[1]}, 32'd40);
    check("other_cfg_cnt1", {24'd0, dut.cnt_q[1]}, 32'd1);
    check("busy_mem151", {24'd0, mem[151]}, 32'd31);

    // Reset while in CAPT abandons the byte.
    cfg(1'b0, 8'd5, 8'd90, 8'd1);
    push(0, 8'd5, 8'd90, 8'd5);
    dreq = 2'b01;
    wait_negedge_bus(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_capt_tri_now", {31'd0, DB_tri}, 32'd0);
    @(posedge clk); #1;
    check("rst_capt_enable", {31'd0, Enable}, 32'd0);
    check("rst_capt_dack",   {30'd0, dack},   32'd0);
    check("rst_capt_addr",   {24'd0, Address}, 32'd0);
    @(negedge clk);
    dreq = 2'b00;
    sb.delete();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_capt_dst_kept", {24'd0, mem[90]}, 32'd90);
    check("rst_capt_done", {30'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
